alu_w_mul: RTL and testbench
============================

ALU_W_MUL -- requirements
Module: alu_w_mul

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset: clk (rising edge) and reset_n.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 S_sel  input  1  slave select; no access occurs when 0.
REQ-005 S_wr  input  1  1 = write, 0 = read; sampled with S_sel.
REQ-006 S_addr  input  8  register address; only bits [2:0] decoded, 0x00-0x07 valid.
REQ-007 S_din  input  32  write data.
REQ-008 S_dout  output  32  read data.

Function
REQ-009 Register map SHALL be: 0x00 OPA (RW, 32b); 0x01 OPB (RW, 32b); 0x02 OPCODE (RW, bits[3:0], upper bits read 0); 0x03 START (W, bit0); 0x04 STATUS (R: bit0 busy, bit1 done; W any value clears done); 0x05 CLEAR (W, bit0); 0x06 RESULT_LO (R); 0x07 RESULT_HI (R).
REQ-010 Write SHALL occur on rising clk when S_sel=1 and S_wr=1; writes to read-only or unmapped addresses have no effect.
REQ-011 S_dout SHALL be combinational: selected register value when S_sel=1 and S_wr=0, else 0; write-only registers read 0.
REQ-012 Writing START with bit0=1 while not busy SHALL launch the operation in OPCODE on OPA/OPB and clear done in the same edge.
REQ-013 Opcodes: 0x0 NOP (result 0); 0x1 ~A; 0x2 ~B; 0x3 A&B; 0x4 A|B; 0x5 A^B; 0x6 ~(A^B); 0x7 A<<B[4:0]; 0x8 A>>B[4:0] logical; 0x9 A>>>B[4:0] arithmetic; 0xA A+B; 0xB A-B; 0xC unsigned A<B ? 1 : 0; 0xD unsigned 32x32 multiply; 0xE/0xF reserved (result 0).
REQ-014 Non-multiply ops SHALL complete in 1 cycle: RESULT_LO/HI and done=1 valid on the edge after START; RESULT_HI = 0 except ADD (bit0 = carry out) and SUB (bit0 = borrow, i.e. A<B unsigned).
REQ-015 Multiply SHALL be a shift-add sequencer of 32 iterations: busy=1 from the START edge for 32 cycles, then RESULT_HI:RESULT_LO = full 64-bit product and done=1, busy=0 on the 33rd edge.
REQ-016 State machine: IDLE -> (START, opcode 0xD) MUL -> (32 iterations) DONE; IDLE -> (START, other) DONE; DONE -> (START) as from IDLE; CLEAR or reset -> IDLE.
REQ-017 While busy, writes to OPA, OPB, OPCODE, START SHALL be ignored; STATUS and RESULT reads remain legal (RESULT holds prior value until completion).
REQ-018 Writing CLEAR bit0=1 SHALL, on that edge, zero OPA, OPB, OPCODE, RESULT_LO/HI, busy, done and abort any multiply in progress.
REQ-019 Done clear (write to 0x04) on the same edge as completion SHALL lose to completion (done=1).

Reset
REQ-020 On reset_n=0, all registers, RESULT_LO/HI, busy, done and sequencer state SHALL go to 0/IDLE immediately, independent of clk; S_dout = 0.
REQ-021 Reset asserted mid-multiply SHALL abort it; no result is produced after release.

Configuration
REQ-022 Macro ALUWMUL_MULTIPLIER_EN: when defined, opcode 0xD SHALL behave per REQ-015; when undefined, no multiplier logic is built and 0xD SHALL act as reserved (1-cycle, result 0, done=1).

Verification
REQ-023 Writes with S_sel=0 (OPA=5, OPB=7) -> read OPA/OPB with S_sel=1 returns 0.
REQ-024 OPA=5, OPB=7, OPCODE=0xB, START=1 -> next cycle STATUS=0x2, RESULT_LO=0xFFFFFFFE, RESULT_HI=1; OPA=3, OPB=9, OPCODE=0xC -> RESULT_LO=1.
REQ-025 OPA=4, OPB=8, OPCODE=0xD, START=1 -> STATUS=0x1 for 32 cycles, then STATUS=0x2, RESULT_LO=0x20, RESULT_HI=0; repeat with 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-026 OPA=5, OPB=3, OPCODE=0xA, START -> RESULT_LO=8, HI=0; then write 0x04 -> STATUS=0; OPA/OPB/OPCODE read back 5/3/0xA.
REQ-027 Start multiply 5x10, write OPA=7 and START during busy -> ignored, result 0x32; CLEAR mid-multiply or reset_n pulse -> STATUS=0, results 0.

Source files
------------

// File: rtl/alu_w_mul.sv
// alu_w_mul: register-mapped ALU with a slave read/write port.
// Optional feature macro ALUWMUL_MULTIPLIER_EN: when defined, opcode 0xD runs a
// 32-iteration shift-add multiplier producing a 64-bit product; when undefined
// no multiplier is built and 0xD completes in one cycle with a zero result.
module alu_w_mul (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        S_sel,
  input  logic        S_wr,
  input  logic [7:0]  S_addr,
  input  logic [31:0] S_din,
  output logic [31:0] S_dout
);

  localparam logic [2:0] ADDR_OPA    = 3'd0;
  localparam logic [2:0] ADDR_OPB    = 3'd1;
  localparam logic [2:0] ADDR_OPCODE = 3'd2;
  localparam logic [2:0] ADDR_START  = 3'd3;
  localparam logic [2:0] ADDR_STATUS = 3'd4;
  localparam logic [2:0] ADDR_CLEAR  = 3'd5;
  localparam logic [2:0] ADDR_RES_LO = 3'd6;
  localparam logic [2:0] ADDR_RES_HI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] opa;
  logic [31:0] opb;
  logic [3:0]  opcode;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        done;
  logic        busy;

  logic [2:0]  reg_addr;
  logic        wr_en;
  logic        wr_opa;
  logic        wr_opb;
  logic        wr_opcode;
  logic        wr_start;
  logic        wr_status;
  logic        wr_clear;

  logic        launch;
  logic        launch_mul;
  logic        mul_finish;
  logic [63:0] mul_product;

  logic [31:0] alu_lo;
  logic [31:0] alu_hi;
  logic [32:0] add_full;
  logic [32:0] sub_full;

  logic        unused_addr_bits;

  assign reg_addr         = S_addr[2:0];
  assign unused_addr_bits = ^S_addr[7:3];
  assign wr_en            = S_sel & S_wr;
  assign busy             = (state == ST_MUL);
  assign launch           = wr_start;

  assign add_full = {1'b0, opa} + {1'b0, opb};
  assign sub_full = {1'b0, opa} - {1'b0, opb};

  // Decode single-cycle write strobes; operand/start writes are masked while the multiplier runs.
  always_comb begin
    wr_opa    = 1'b0;
    wr_opb    = 1'b0;
    wr_opcode = 1'b0;
    wr_start  = 1'b0;
    wr_status = 1'b0;
    wr_clear  = 1'b0;
    if (wr_en) begin
      case (reg_addr)
        ADDR_OPA:    wr_opa    = !busy;
        ADDR_OPB:    wr_opb    = !busy;
        ADDR_OPCODE: wr_opcode = !busy;
        ADDR_START:  wr_start  = !busy && S_din[0];
        ADDR_STATUS: wr_status = 1'b1;
        ADDR_CLEAR:  wr_clear  = S_din[0];
        default:     ;
      endcase
    end
  end

`ifdef ALUWMUL_MULTIPLIER_EN
  logic [31:0] mul_mcand;
  logic [63:0] mul_acc;
  logic [4:0]  mul_count;
  logic [32:0] mul_partial;

  assign launch_mul  = launch && (opcode == 4'hD);
  assign mul_finish  = busy && (mul_count == 5'd31);
  assign mul_partial = {1'b0, mul_acc[63:32]} + (mul_acc[0] ? {1'b0, mul_mcand} : 33'd0);
  assign mul_product = {mul_partial, mul_acc[31:1]};

  // One add-and-shift step per cycle: the low half starts as the multiplier and drains out as the product fills in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_mcand <= '0;
      mul_acc   <= '0;
      mul_count <= '0;
    end else if (wr_clear) begin
      mul_mcand <= '0;
      mul_acc   <= '0;
      mul_count <= '0;
    end else if (launch_mul) begin
      mul_mcand <= opa;
      mul_acc   <= {32'd0, opb};
      mul_count <= '0;
    end else if (busy) begin
      mul_acc   <= mul_product;
      mul_count <= mul_count + 5'd1;
    end
  end
`else
  assign launch_mul  = 1'b0;
  assign mul_finish  = 1'b0;
  assign mul_product = 64'd0;
`endif

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: a start goes straight to DONE unless it launches the multiplier; clear always wins.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          next_state = launch_mul ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_finish) begin
          next_state = ST_DONE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
    if (wr_clear) begin
      next_state = ST_IDLE;
    end
  end

  // Single-cycle ALU; HI carries only the add carry-out or subtract borrow.
  always_comb begin
    alu_lo = 32'd0;
    alu_hi = 32'd0;
    case (opcode)
      4'h1: alu_lo = ~opa;
      4'h2: alu_lo = ~opb;
      4'h3: alu_lo = opa & opb;
      4'h4: alu_lo = opa | opb;
      4'h5: alu_lo = opa ^ opb;
      4'h6: alu_lo = ~(opa ^ opb);
      4'h7: alu_lo = opa << opb[4:0];
      4'h8: alu_lo = opa >> opb[4:0];
      4'h9: alu_lo = 32'($signed(opa) >>> opb[4:0]);
      4'hA: begin
        alu_lo = add_full[31:0];
        alu_hi = {31'd0, add_full[32]};
      end
      4'hB: begin
        alu_lo = sub_full[31:0];
        alu_hi = {31'd0, sub_full[32]};
      end
      4'hC: alu_lo = {31'd0, (opa < opb)};
      default: ;
    endcase
  end

  // Operand registers accept writes only while idle and are zeroed by clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa    <= '0;
      opb    <= '0;
      opcode <= '0;
    end else if (wr_clear) begin
      opa    <= '0;
      opb    <= '0;
      opcode <= '0;
    end else begin
      if (wr_opa) begin
        opa <= S_din;
      end
      if (wr_opb) begin
        opb <= S_din;
      end
      if (wr_opcode) begin
        opcode <= S_din[3:0];
      end
    end
  end

  // Result registers keep their old value through a multiply and update only on completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_lo <= '0;
      result_hi <= '0;
    end else if (wr_clear) begin
      result_lo <= '0;
      result_hi <= '0;
    end else if (mul_finish) begin
      result_lo <= mul_product[31:0];
      result_hi <= mul_product[63:32];
    end else if (launch && !launch_mul) begin
      result_lo <= alu_lo;
      result_hi <= alu_hi;
    end
  end

  // Done flag: completion takes priority over a same-edge status write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done <= 1'b0;
    end else if (wr_clear) begin
      done <= 1'b0;
    end else if (mul_finish) begin
      done <= 1'b1;
    end else if (launch) begin
      done <= !launch_mul;
    end else if (wr_status) begin
      done <= 1'b0;
    end
  end

  // Combinational read mux; write-only locations and non-read cycles return zero.
  always_comb begin
    S_dout = 32'd0;
    if (S_sel && !S_wr) begin
      case (reg_addr)
        ADDR_OPA:    S_dout = opa;
        ADDR_OPB:    S_dout = opb;
        ADDR_OPCODE: S_dout = {28'd0, opcode};
        ADDR_STATUS: S_dout = {30'd0, done, busy};
        ADDR_RES_LO: S_dout = result_lo;
        ADDR_RES_HI: S_dout = result_hi;
        default:     S_dout = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_w_mul.sv
// tb_alu_w_mul: randomized and directed register-level stimulus against a
// behavioural model; a monitor pops queued expectations on every read cycle.
`timescale 1ns/1ps
module tb_alu_w_mul;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        S_sel = 1'b0;
  logic        S_wr = 1'b0;
  logic [7:0]  S_addr = 8'd0;
  logic [31:0] S_din = 32'd0;
  logic [31:0] S_dout;

  localparam logic [7:0] A_OPA    = 8'h00;
  localparam logic [7:0] A_OPB    = 8'h01;
  localparam logic [7:0] A_OPCODE = 8'h02;
  localparam logic [7:0] A_START  = 8'h03;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_CLEAR  = 8'h05;
  localparam logic [7:0] A_RES_LO = 8'h06;
  localparam logic [7:0] A_RES_HI = 8'h07;

`ifdef ALUWMUL_MULTIPLIER_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_item;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] m_opa;
  logic [31:0] m_opb;
  logic [3:0]  m_op;
  logic [31:0] m_lo;
  logic [31:0] m_hi;
  bit          m_done;
  int          m_busy_left;
  logic [63:0] m_pend;

  alu_w_mul dut (
    .clk     (clk),
    .reset_n (reset_n),
    .S_sel   (S_sel),
    .S_wr    (S_wr),
    .S_addr  (S_addr),
    .S_din   (S_din),
    .S_dout  (S_dout)
  );

  always #5 clk = ~clk;

  // Reference operation: full {HI,LO} result computed with plain arithmetic.
  function automatic logic [63:0] model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    logic [31:0] t;
    wa = {32'd0, a};
    wb = {32'd0, b};
    case (op)
      4'h1: return {32'd0, ~a};
      4'h2: return {32'd0, ~b};
      4'h3: return {32'd0, a & b};
      4'h4: return {32'd0, a | b};
      4'h5: return {32'd0, a ^ b};
      4'h6: return {32'd0, ~(a ^ b)};
      4'h7: begin t = a << b[4:0]; return {32'd0, t}; end
      4'h8: begin t = a >> b[4:0]; return {32'd0, t}; end
      4'h9: begin t = 32'($signed(a) >>> b[4:0]); return {32'd0, t}; end
      4'hA: return wa + wb;
      4'hB: begin t = a - b; return {31'd0, (a < b), t}; end
      4'hC: return (a < b) ? 64'd1 : 64'd0;
      4'hD: return MUL_EN ? wa * wb : 64'd0;
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [7:0] addr);
    case (addr[2:0])
      3'd0: return m_opa;
      3'd1: return m_opb;
      3'd2: return {28'd0, m_op};
      3'd4: return {30'd0, m_done, (m_busy_left > 0)};
      3'd6: return m_lo;
      3'd7: return m_hi;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_opa = '0; m_opb = '0; m_op = '0; m_lo = '0; m_hi = '0;
    m_done = 1'b0; m_busy_left = 0; m_pend = '0;
  endtask

  // Model state change for one clock edge carrying the given bus access.
  task automatic model_edge(input bit sel, input bit wr, input logic [7:0] addr, input logic [31:0] din);
    bit was_busy;
    bit finishing;
    logic [63:0] r;
    was_busy  = (m_busy_left > 0);
    finishing = (m_busy_left == 1);
    if (was_busy) m_busy_left--;
    if (finishing) begin
      {m_hi, m_lo} = m_pend;
      m_done = 1'b1;
    end
    if (sel && wr) begin
      case (addr[2:0])
        3'd0: if (!was_busy) m_opa = din;
        3'd1: if (!was_busy) m_opb = din;
        3'd2: if (!was_busy) m_op = din[3:0];
        3'd3: if (!was_busy && din[0]) begin
          r = model_op(m_op, m_opa, m_opb);
          if (MUL_EN && m_op == 4'hD) begin
            m_pend = r;
            m_busy_left = 32;
            m_done = 1'b0;
          end else begin
            {m_hi, m_lo} = r;
            m_done = 1'b1;
          end
        end
        3'd4: if (!finishing) m_done = 1'b0;
        3'd5: if (din[0]) model_reset();
        default: ;
      endcase
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: S_dout=0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  // One bus cycle, starting just after a rising edge; reads queue their expectation first.
  task automatic apply_stimulus(input bit sel, input bit wr, input logic [7:0] addr, input logic [31:0] din,
                                input string name = "read", input bit use_const = 1'b0,
                                input logic [31:0] const_val = 32'd0);
    exp_t item;
    S_sel  = sel;
    S_wr   = wr;
    S_addr = addr;
    S_din  = din;
    if (sel && !wr) begin
      item.data = use_const ? const_val : model_read(addr);
      item.name = name;
      exp_q.push_back(item);
    end
    @(posedge clk);
    if (!reset_n) model_reset();
    else model_edge(sel, wr, addr, din);
    #1;
  endtask

  task automatic wr_reg(input logic [7:0] addr, input logic [31:0] data);
    apply_stimulus(1'b1, 1'b1, addr, data, "write");
  endtask

  task automatic rd_model(input logic [7:0] addr, input string name);
    apply_stimulus(1'b1, 1'b0, addr, 32'd0, name);
  endtask

  task automatic rd_const(input logic [7:0] addr, input logic [31:0] val, input string name);
    apply_stimulus(1'b1, 1'b0, addr, 32'd0, name, 1'b1, val);
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, 8'd0, 32'd0, "idle");
  endtask

  // Monitor: every read cycle pops one expectation; otherwise the port must drive zero.
  always @(negedge clk) begin
    if (S_sel && !S_wr) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_read: S_dout=0x%08h with nothing queued", S_dout);
      end else begin
        mon_item = exp_q.pop_front();
        check_output(mon_item.name, S_dout, mon_item.data);
      end
    end else begin
      check_output("idle_dout", S_dout, 32'd0);
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    model_reset();
    @(posedge clk);
    #1;

    rd_const(A_OPA, 32'd0, "rst_opa");
    rd_const(A_STATUS, 32'd0, "rst_status");
    rd_const(A_RES_LO, 32'd0, "rst_res_lo");
    reset_n = 1'b1;

    apply_stimulus(1'b0, 1'b1, A_OPA, 32'd5, "unsel_wr");
    apply_stimulus(1'b0, 1'b1, A_OPB, 32'd7, "unsel_wr");
    rd_const(A_OPA, 32'd0, "unsel_opa");
    rd_const(A_OPB, 32'd0, "unsel_opb");

    wr_reg(A_OPA, 32'd5);
    wr_reg(A_OPB, 32'd7);
    wr_reg(A_OPCODE, 32'hB);
    wr_reg(A_START, 32'd1);
    rd_const(A_STATUS, 32'h2, "sub_status");
    rd_const(A_RES_LO, 32'hFFFF_FFFE, "sub_lo");
    rd_const(A_RES_HI, 32'd1, "sub_borrow");
    wr_reg(A_OPA, 32'd3);
    wr_reg(A_OPB, 32'd9);
    wr_reg(A_OPCODE, 32'hC);
    wr_reg(A_START, 32'd1);
    rd_const(A_RES_LO, 32'd1, "slt_lo");
    rd_const(A_RES_HI, 32'd0, "slt_hi");

    wr_reg(A_OPA, 32'd5);
    wr_reg(A_OPB, 32'd3);
    wr_reg(A_OPCODE, 32'hA);
    wr_reg(A_START, 32'd1);
    rd_const(A_RES_LO, 32'd8, "add_lo");
    rd_const(A_RES_HI, 32'd0, "add_hi");
    wr_reg(A_STATUS, 32'd0);
    rd_const(A_STATUS, 32'd0, "done_cleared");
    rd_const(A_OPA, 32'd5, "keep_opa");
    rd_const(A_OPB, 32'd3, "keep_opb");
    rd_const(A_OPCODE, 32'hA, "keep_opcode");
    rd_const(8'h0A, 32'hA, "alias_opcode");
    rd_const(A_START, 32'd0, "start_reads0");
    wr_reg(A_RES_LO, 32'h1234_5678);
    rd_const(A_RES_LO, 32'd8, "ro_write_ignored");
    wr_reg(A_CLEAR, 32'h2);
    rd_const(A_OPA, 32'd5, "clear_bit0_low");

    wr_reg(A_OPA, 32'd4);
    wr_reg(A_OPB, 32'd8);
    wr_reg(A_OPCODE, 32'hD);
    wr_reg(A_START, 32'd1);
    for (int i = 0; i < 32; i++) rd_model(A_STATUS, "mul_busy_status");
    rd_model(A_STATUS, "mul_done_status");
    rd_const(A_RES_LO, MUL_EN ? 32'h20 : 32'h0, "mul_4x8_lo");
    rd_const(A_RES_HI, 32'd0, "mul_4x8_hi");

    wr_reg(A_OPA, 32'hFFFF_FFFF);
    wr_reg(A_OPB, 32'hFFFF_FFFF);
    wr_reg(A_START, 32'd1);
    for (int i = 0; i < 31; i++) idle_cycle();
    wr_reg(A_STATUS, 32'd0);
    rd_model(A_STATUS, "done_clear_vs_finish");
    rd_const(A_RES_HI, MUL_EN ? 32'hFFFF_FFFE : 32'h0, "mul_max_hi");
    rd_const(A_RES_LO, MUL_EN ? 32'h0000_0001 : 32'h0, "mul_max_lo");

    wr_reg(A_OPA, 32'd5);
    wr_reg(A_OPB, 32'd10);
    wr_reg(A_START, 32'd1);
    wr_reg(A_OPA, 32'd7);
    wr_reg(A_START, 32'd1);
    for (int i = 0; i < 34; i++) rd_model(A_STATUS, "busy_poll");
    rd_const(A_RES_LO, MUL_EN ? 32'h32 : 32'h0, "mul_5x10_lo");
    rd_model(A_OPA, "opa_busy_write");

    wr_reg(A_START, 32'd1);
    for (int i = 0; i < 5; i++) idle_cycle();
    wr_reg(A_CLEAR, 32'd1);
    rd_const(A_STATUS, 32'd0, "clear_status");
    rd_const(A_RES_LO, 32'd0, "clear_lo");
    rd_const(A_RES_HI, 32'd0, "clear_hi");
    rd_const(A_OPA, 32'd0, "clear_opa");

    wr_reg(A_OPA, 32'd9);
    wr_reg(A_OPB, 32'd9);
    wr_reg(A_OPCODE, 32'hD);
    wr_reg(A_START, 32'd1);
    for (int i = 0; i < 10; i++) idle_cycle();
    #2;
    reset_n = 1'b0;
    model_reset();
    rd_const(A_STATUS, 32'd0, "async_rst_status");
    rd_const(A_OPB, 32'd0, "async_rst_opb");
    reset_n = 1'b1;
    for (int i = 0; i < 36; i++) rd_model(A_STATUS, "post_rst_status");
    rd_const(A_RES_LO, 32'd0, "post_rst_lo");
    rd_const(A_RES_HI, 32'd0, "post_rst_hi");

    for (int n = 0; n < 80; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: a = 32'hFFFF_FFFF;
        1: b = 32'hFFFF_FFFF;
        2: b = {27'd0, 5'($urandom)};
        default: ;
      endcase
      op = 4'($urandom_range(0, 15));
      wr_reg(A_OPA, a);
      wr_reg(A_OPB, b);
      wr_reg(A_OPCODE, {28'($urandom), op});
      wr_reg(A_START, {31'($urandom), 1'b1});
      for (int k = 0; k < 40 && m_busy_left > 0; k++) begin
        case ($urandom_range(0, 9))
          0, 1, 2: wr_reg(8'($urandom_range(0, 3)), $urandom);
          3:       wr_reg(A_STATUS, $urandom);
          default: rd_model(8'($urandom_range(0, 255)), "rand_busy_read");
        endcase
      end
      rd_model(A_STATUS, "rand_status");
      rd_model(A_RES_LO, "rand_lo");
      rd_model(A_RES_HI, "rand_hi");
      rd_model(A_OPCODE, "rand_opcode");
      if ($urandom_range(0, 4) == 0) wr_reg(A_STATUS, $urandom);
      if ($urandom_range(0, 9) == 0) wr_reg(A_CLEAR, $urandom);
    end

    idle_cycle();
    idle_cycle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drained: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
